// File: rtl/timebase_tick_gen.sv
// Microsecond/millisecond time base.
// Divides theclk into one-cycle us/ms strobes, keeps free-running us/ms
// counters, and provides a sticky millisecond alarm and a sticky ms overflow flag.
//
// Ports:
//   theclk, theresetn : clock, asynchronous active-low reset
//   en                : count enable; low freezes all counters
//   clr               : synchronous clear of prescaler/us/ms counters, ticks, ms_ovf
//   alarm_en          : arm the millisecond alarm compare
//   alarm_ms          : alarm compare value
//   alarm_clr         : clear the sticky alarm flag
//   us_tick, ms_tick  : one-cycle strobes per microsecond / millisecond
//   us_cnt            : microseconds within the current millisecond
//   ms_cnt            : elapsed milliseconds, wraps to 0
//   alarm             : sticky, ms_cnt reached alarm_ms while armed
//   ms_ovf            : sticky, ms_cnt wrapped from all-ones to 0
module timebase_tick_gen #(
    parameter int unsigned CLK_PER_US = 100,
    parameter int unsigned US_PER_MS  = 1000,
    parameter int unsigned MS_W       = 32,
    localparam int unsigned US_W      = $clog2(US_PER_MS)
) (
    input  logic            theclk,
    input  logic            theresetn,
    input  logic            en,
    input  logic            clr,
    input  logic            alarm_en,
    input  logic [MS_W-1:0] alarm_ms,
    input  logic            alarm_clr,
    output logic            us_tick,
    output logic            ms_tick,
    output logic [US_W-1:0] us_cnt,
    output logic [MS_W-1:0] ms_cnt,
    output logic            alarm,
    output logic            ms_ovf
);

    // A divide-by-1 prescaler still needs a 1-bit register to stay legal.
    localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_cnt_nxt;
    logic [US_W-1:0]  us_cnt_nxt;
    logic [MS_W-1:0]  ms_cnt_nxt;
    logic [MS_W-1:0]  ms_inc_c;
    logic             us_tick_nxt;
    logic             ms_tick_nxt;
    logic             alarm_nxt;
    logic             ms_ovf_nxt;
    logic             pre_term_c;
    logic             us_term_c;

    assign pre_term_c = (pre_cnt == PRE_W'(CLK_PER_US - 1));
    assign us_term_c  = (us_cnt == US_W'(US_PER_MS - 1));
    assign ms_inc_c   = ms_cnt + MS_W'(1);

    // Next-state computation: clr beats en; alarm set beats alarm_clr.
    always_comb begin
        pre_cnt_nxt = pre_cnt;
        us_cnt_nxt  = us_cnt;
        ms_cnt_nxt  = ms_cnt;
        us_tick_nxt = 1'b0;
        ms_tick_nxt = 1'b0;
        ms_ovf_nxt  = ms_ovf;
        alarm_nxt   = alarm_clr ? 1'b0 : alarm;

        if (clr) begin
            pre_cnt_nxt = '0;
            us_cnt_nxt  = '0;
            ms_cnt_nxt  = '0;
            ms_ovf_nxt  = 1'b0;
        end else if (en) begin
            if (pre_term_c) begin
                pre_cnt_nxt = '0;
                us_tick_nxt = 1'b1;
                if (us_term_c) begin
                    us_cnt_nxt  = '0;
                    ms_tick_nxt = 1'b1;
                    ms_cnt_nxt  = ms_inc_c;
                    if (&ms_cnt) begin
                        ms_ovf_nxt = 1'b1;
                    end
                    // Compare against the value being loaded, not the old one.
                    if (alarm_en && (ms_inc_c == alarm_ms)) begin
                        alarm_nxt = 1'b1;
                    end
                end else begin
                    us_cnt_nxt = us_cnt + US_W'(1);
                end
            end else begin
                pre_cnt_nxt = pre_cnt + PRE_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge theclk or negedge theresetn) begin
        if (!theresetn) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
            ms_cnt  <= '0;
            us_tick <= 1'b0;
            ms_tick <= 1'b0;
            alarm   <= 1'b0;
            ms_ovf  <= 1'b0;
        end else begin
            pre_cnt <= pre_cnt_nxt;
            us_cnt  <= us_cnt_nxt;
            ms_cnt  <= ms_cnt_nxt;
            us_tick <= us_tick_nxt;
            ms_tick <= ms_tick_nxt;
            alarm   <= alarm_nxt;
            ms_ovf  <= ms_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_timebase_tick_gen.sv
// Bench for timebase_tick_gen: two instances (CLK_PER_US=4 and 1, US_PER_MS=10,
// MS_W=4) checked every cycle against a model built on the count of enabled
// edges since the last clear/reset.
module tb_timebase_tick_gen;

    localparam int unsigned UPM = 10;
    localparam int unsigned MSW = 4;
    localparam int unsigned USW = 4;

    logic           theclk;
    logic           theresetn;
    logic           en;
    logic           clr;
    logic           alarm_en;
    logic [MSW-1:0] alarm_ms;
    logic           alarm_clr;
    logic           us_tick [2];
    logic           ms_tick [2];
    logic [USW-1:0] us_cnt  [2];
    logic [MSW-1:0] ms_cnt  [2];
    logic           alarm   [2];
    logic           ms_ovf  [2];

    timebase_tick_gen #(.CLK_PER_US(4), .US_PER_MS(UPM), .MS_W(MSW)) u_dut0 (
        .theclk(theclk), .theresetn(theresetn), .en(en), .clr(clr),
        .alarm_en(alarm_en), .alarm_ms(alarm_ms), .alarm_clr(alarm_clr),
        .us_tick(us_tick[0]), .ms_tick(ms_tick[0]), .us_cnt(us_cnt[0]),
        .ms_cnt(ms_cnt[0]), .alarm(alarm[0]), .ms_ovf(ms_ovf[0])
    );

    timebase_tick_gen #(.CLK_PER_US(1), .US_PER_MS(UPM), .MS_W(MSW)) u_dut1 (
        .theclk(theclk), .theresetn(theresetn), .en(en), .clr(clr),
        .alarm_en(alarm_en), .alarm_ms(alarm_ms), .alarm_clr(alarm_clr),
        .us_tick(us_tick[1]), .ms_tick(ms_tick[1]), .us_cnt(us_cnt[1]),
        .ms_cnt(ms_cnt[1]), .alarm(alarm[1]), .ms_ovf(ms_ovf[1])
    );

    initial theclk = 1'b0;
    always #5 theclk = ~theclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: enabled edges since clear, plus sticky flags and last-edge ticks.
    longint m_e   [2];
    bit     m_ut  [2];
    bit     m_mt  [2];
    bit     m_ovf [2];
    bit     m_alm [2];

    function automatic longint cpu_of(int k);
        return (k == 0) ? 64'd4 : 64'd1;
    endfunction

    task automatic chk(string tag, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_e[k] = 0; m_ut[k] = 0; m_mt[k] = 0; m_ovf[k] = 0; m_alm[k] = 0;
        end
    endtask

    task automatic model_edge(int k, bit e, bit c, bit ae, logic [MSW-1:0] am, bit ac);
        longint cpu;
        longint us_total;
        longint ms_total;
        bit     set;
        cpu = cpu_of(k);
        set = 0;
        m_ut[k] = 0;
        m_mt[k] = 0;
        if (c) begin
            m_e[k]   = 0;
            m_ovf[k] = 0;
        end else if (e) begin
            m_e[k]++;
            us_total = m_e[k] / cpu;
            m_ut[k]  = (m_e[k] % cpu) == 0;
            m_mt[k]  = m_ut[k] && ((us_total % UPM) == 0);
            if (m_mt[k]) begin
                ms_total = us_total / UPM;
                if ((ms_total % 16) == 0) m_ovf[k] = 1;
                set = ae && ((ms_total % 16) == longint'(am));
            end
        end
        if (set) m_alm[k] = 1;
        else if (ac) m_alm[k] = 0;
    endtask

    task automatic check_all();
        longint cpu;
        for (int k = 0; k < 2; k++) begin
            cpu = cpu_of(k);
            chk($sformatf("d%0d_us_tick", k), longint'(us_tick[k]), longint'(m_ut[k]));
            chk($sformatf("d%0d_ms_tick", k), longint'(ms_tick[k]), longint'(m_mt[k]));
            chk($sformatf("d%0d_us_cnt", k), longint'(us_cnt[k]), (m_e[k] / cpu) % UPM);
            chk($sformatf("d%0d_ms_cnt", k), longint'(ms_cnt[k]), (m_e[k] / cpu / UPM) % 16);
            chk($sformatf("d%0d_alarm", k), longint'(alarm[k]), longint'(m_alm[k]));
            chk($sformatf("d%0d_ms_ovf", k), longint'(ms_ovf[k]), longint'(m_ovf[k]));
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
    task automatic step(bit e, bit c, bit ae, logic [MSW-1:0] am, bit ac);
        en = e; clr = c; alarm_en = ae; alarm_ms = am; alarm_clr = ac;
        @(posedge theclk);
        for (int k = 0; k < 2; k++) model_edge(k, e, c, ae, am, ac);
        #1;
        check_all();
    endtask

    initial begin
        bit r_en;
        bit r_clr;
        bit r_ae;
        bit r_ac;
        logic [MSW-1:0] r_am;

        theresetn = 1'b0;
        en = 0; clr = 0; alarm_en = 0; alarm_ms = '0; alarm_clr = 0;
        model_reset();
        repeat (2) @(posedge theclk);
        #1;
        check_all();
        theresetn = 1'b1;

        // Ticks at enabled edges 4/8/12, first ms at edge 40, both low on 41.
        for (int i = 1; i <= 41; i++) begin
            step(1, 0, 0, '0, 0);
            if (i == 4) begin
                chk("t1_us_tick_e4", longint'(us_tick[0]), 1);
                chk("t1_us_cnt_e4", longint'(us_cnt[0]), 1);
            end
            if (i == 40) begin
                chk("t2_ms_tick_e40", longint'(ms_tick[0]), 1);
                chk("t2_us_tick_e40", longint'(us_tick[0]), 1);
                chk("t2_ms_cnt_e40", longint'(ms_cnt[0]), 1);
                chk("t2_us_cnt_e40", longint'(us_cnt[0]), 0);
            end
            if (i == 41) begin
                chk("t2_ms_tick_e41", longint'(ms_tick[0]), 0);
                chk("t2_us_tick_e41", longint'(us_tick[0]), 0);
            end
            chk("t6_us_tick_cpu1", longint'(us_tick[1]), 1);
        end

        // Freeze after two enabled edges; first tick lands on wall edge 11.
        step(0, 1, 0, '0, 0);
        for (int i = 1; i <= 12; i++) begin
            step((i <= 2) || (i >= 10), 0, 0, '0, 0);
            if (i == 11) chk("t3_us_tick_w11", longint'(us_tick[0]), 1);
            if (i == 10) chk("t3_us_tick_w10", longint'(us_tick[0]), 0);
        end

        // Alarm at ms 3 (edge 120) with a simultaneous clear, then a later clear.
        step(0, 1, 0, '0, 1);
        for (int i = 1; i <= 120; i++) step(1, 0, 1, 4'd3, i == 120);
        chk("t4_alarm_set_wins", longint'(alarm[0]), 1);
        step(0, 0, 1, 4'd3, 1);
        chk("t4_alarm_cleared", longint'(alarm[0]), 0);

        // 16 ms wrap sets ms_ovf; clr drops it but leaves the alarm.
        step(0, 1, 0, '0, 1);
        for (int i = 1; i <= 640; i++) step(1, 0, 1, 4'd5, 0);
        chk("t5_ms_cnt_wrap", longint'(ms_cnt[0]), 0);
        chk("t5_ms_ovf_set", longint'(ms_ovf[0]), 1);
        step(1, 1, 0, '0, 0);
        chk("t5_ms_ovf_clr", longint'(ms_ovf[0]), 0);
        chk("t5_alarm_kept", longint'(alarm[0]), 1);

        // Asynchronous reset mid-cycle at us_cnt=5.
        for (int i = 1; i <= 20; i++) step(1, 0, 0, '0, 0);
        chk("t6_us_cnt_pre", longint'(us_cnt[0]), 5);
        #2;
        theresetn = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        theresetn = 1'b1;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            r_en  = ($urandom_range(0, 9) != 0);
            r_clr = ($urandom_range(0, 499) == 0);
            r_ae  = ($urandom_range(0, 3) != 0);
            r_am  = MSW'($urandom_range(0, 15));
            r_ac  = ($urandom_range(0, 29) == 0);
            step(r_en, r_clr, r_ae, r_am, r_ac);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
